// File: rtl/uart_pkg.sv
// Shared UART constants used by the receiver, transmitter and receive FIFO.
package uart_pkg;

  localparam int DATA_SIZE             = 8;
  localparam int RX_FIFO_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous level (rx_done, rx line).
module uart_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO for the UART: synchronizes the receiver's frame-done level, writes one byte
// per rising edge of it, and presents the head entry first-word-fall-through.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH     = RX_FIFO_DEPTH_DEFAULT,
  parameter int DATA_SIZE = uart_pkg::DATA_SIZE
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   rx_done_in,
  input  logic [DATA_SIZE-1:0]   rx_data_in,
  output logic                   m_valid,
  output logic [DATA_SIZE-1:0]   m_data,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   overrun,
  input  logic                   clr_overrun
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic                 done_sync;
  logic                 edge_q;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overrun_q, overrun_d;
  logic [DATA_SIZE-1:0] mem_q [DEPTH];

  logic wr_pulse;
  logic pop;
  logic push;
  logic is_full;

  uart_sync2 u_done_sync (
    .clk_i (clk),
    .rst_ni(reset_n),
    .d_i   (rx_done_in),
    .q_o   (done_sync)
  );

  // A write while full is only accepted when the head is leaving on the same edge.
  always_comb begin
    wr_pulse  = done_sync & ~edge_q;
    is_full   = (count_q == FULL_COUNT);
    pop       = m_valid & m_ready;
    push      = wr_pulse & (~is_full | pop);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (clr_overrun) overrun_d = 1'b0;
    if (wr_pulse && is_full && !pop) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      edge_q    <= done_sync;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data_in;
  end

  // Gate the head with m_valid so unreset storage never leaks onto m_data.
  assign m_valid = (count_q != '0);
  assign m_data  = m_valid ? mem_q[rd_ptr_q] : '0;
  assign count   = count_q;
  assign full    = is_full;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at DEPTH=16: bytes expected out are queued as they are sent
// and checked in order as the FIFO is drained.
module tb_uart_rx_fifo;

  logic       clk;
  logic       reset_n;
  logic       rx_done_in;
  logic [7:0] rx_data_in;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic [4:0] count;
  logic       full;
  logic       overrun;
  logic       clr_overrun;

  int         nCompared;
  int         nMismatched;
  logic [7:0] sb[$];
  logic [7:0] expData;

  uart_rx_fifo #(.DEPTH(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_done_in (rx_done_in),
    .rx_data_in (rx_data_in),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .count      (count),
    .full       (full),
    .overrun    (overrun),
    .clr_overrun(clr_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Called at a falling edge; the write lands on the third rising edge, then the level
  // stays low long enough for the next byte to be seen as a new frame.
  task automatic applyStimulus(input logic [7:0] d);
    rx_data_in = d;
    rx_done_in = 1'b1;
    repeat (3) @(negedge clk);
    rx_done_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; rx_done_in = 1'b0; rx_data_in = 8'h00; m_ready = 1'b1; clr_overrun = 1'b0;
    #3;
    nCompared++; if (count !== 5'd0)  begin nMismatched++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    nCompared++; if (m_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", m_valid); end
    nCompared++; if (full !== 1'b0)    begin nMismatched++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
    nCompared++; if (overrun !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
    nCompared++; if (m_data !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_data: got %h expected 00", m_data); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    nCompared++; if (count !== 5'd0) begin nMismatched++; $display("[TB] FAIL empty_ready_count: got %0d expected 0", count); end
    m_ready = 1'b0;
  endtask

  task automatic test_single_byte;
    rx_data_in = 8'hA5;
    rx_done_in = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      nCompared++;
      if (m_valid !== (k == 3)) begin
        nMismatched++; $display("[TB] FAIL latency_valid_edge%0d: got %b expected %b", k, m_valid, (k == 3));
      end
    end
    nCompared++; if (m_data !== 8'hA5) begin nMismatched++; $display("[TB] FAIL single_data: got %h expected a5", m_data); end
    nCompared++; if (count !== 5'd1)   begin nMismatched++; $display("[TB] FAIL single_count: got %0d expected 1", count); end
    rx_done_in = 1'b0;
    sb.push_back(8'hA5);
    m_ready = 1'b1;
    while (sb.size() > 0) begin
      expData = sb.pop_front();
      nCompared++;
      if (m_valid !== 1'b1 || m_data !== expData) begin
        nMismatched++; $display("[TB] FAIL single_drain: got v=%b %h expected v=1 %h", m_valid, m_data, expData);
      end
      @(negedge clk);
    end
    m_ready = 1'b0;
    nCompared++; if (m_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_empty: got %b expected 0", m_valid); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fill_overflow;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(8'(i));
      sb.push_back(8'(i));
    end
    nCompared++; if (full !== 1'b1)    begin nMismatched++; $display("[TB] FAIL fill_full: got %b expected 1", full); end
    nCompared++; if (count !== 5'd16)  begin nMismatched++; $display("[TB] FAIL fill_count: got %0d expected 16", count); end
    nCompared++; if (overrun !== 1'b0) begin nMismatched++; $display("[TB] FAIL fill_overrun: got %b expected 0", overrun); end
    applyStimulus(8'h10);
    nCompared++; if (overrun !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf_overrun: got %b expected 1", overrun); end
    nCompared++; if (count !== 5'd16)  begin nMismatched++; $display("[TB] FAIL ovf_count: got %0d expected 16", count); end
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    nCompared++; if (overrun !== 1'b0) begin nMismatched++; $display("[TB] FAIL clr_overrun: got %b expected 0", overrun); end
    rx_data_in = 8'h11;
    rx_done_in = 1'b1;
    repeat (2) @(negedge clk);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    rx_done_in = 1'b0;
    nCompared++; if (overrun !== 1'b1) begin nMismatched++; $display("[TB] FAIL set_wins: got %b expected 1", overrun); end
    nCompared++; if (count !== 5'd16)  begin nMismatched++; $display("[TB] FAIL set_wins_count: got %0d expected 16", count); end
    repeat (2) @(negedge clk);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    m_ready = 1'b1;
    while (sb.size() > 0) begin
      expData = sb.pop_front();
      nCompared++;
      if (m_valid !== 1'b1 || m_data !== expData) begin
        nMismatched++; $display("[TB] FAIL fill_drain: got v=%b %h expected v=1 %h", m_valid, m_data, expData);
      end
      @(negedge clk);
    end
    m_ready = 1'b0;
    nCompared++; if (m_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL fill_extra_entry: got %b expected 0", m_valid); end
    nCompared++; if (overrun !== 1'b0) begin nMismatched++; $display("[TB] FAIL fill_end_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_write_pop_full;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(8'(8'h20 + i));
      sb.push_back(8'(8'h20 + i));
    end
    rx_data_in = 8'h30;
    rx_done_in = 1'b1;
    repeat (2) @(negedge clk);
    m_ready = 1'b1;
    expData = sb.pop_front();
    nCompared++;
    if (m_data !== expData) begin
      nMismatched++; $display("[TB] FAIL wpf_head: got %h expected %h", m_data, expData);
    end
    sb.push_back(8'h30);
    @(negedge clk);
    m_ready = 1'b0;
    rx_done_in = 1'b0;
    nCompared++; if (count !== 5'd16)  begin nMismatched++; $display("[TB] FAIL wpf_count: got %0d expected 16", count); end
    nCompared++; if (overrun !== 1'b0) begin nMismatched++; $display("[TB] FAIL wpf_overrun: got %b expected 0", overrun); end
    nCompared++; if (full !== 1'b1)    begin nMismatched++; $display("[TB] FAIL wpf_full: got %b expected 1", full); end
    repeat (2) @(negedge clk);
    m_ready = 1'b1;
    while (sb.size() > 0) begin
      expData = sb.pop_front();
      nCompared++;
      if (m_valid !== 1'b1 || m_data !== expData) begin
        nMismatched++; $display("[TB] FAIL wpf_drain: got v=%b %h expected v=1 %h", m_valid, m_data, expData);
      end
      @(negedge clk);
    end
    m_ready = 1'b0;
    nCompared++; if (m_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL wpf_empty: got %b expected 0", m_valid); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(8'(8'h40 + i));
      sb.push_back(8'(8'h40 + i));
      if (i % 3 != 0) begin
        m_ready = 1'b1;
        expData = sb.pop_front();
        nCompared++;
        if (m_valid !== 1'b1 || m_data !== expData) begin
          nMismatched++; $display("[TB] FAIL wrap_pop%0d: got v=%b %h expected v=1 %h", i, m_valid, m_data, expData);
        end
        @(negedge clk);
        m_ready = 1'b0;
      end
      nCompared++;
      if (count !== 5'(sb.size()) || count > 5'd16) begin
        nMismatched++; $display("[TB] FAIL wrap_count%0d: got %0d expected %0d", i, count, sb.size());
      end
    end
    m_ready = 1'b1;
    while (sb.size() > 0) begin
      expData = sb.pop_front();
      nCompared++;
      if (m_valid !== 1'b1 || m_data !== expData) begin
        nMismatched++; $display("[TB] FAIL wrap_drain: got v=%b %h expected v=1 %h", m_valid, m_data, expData);
      end
      @(negedge clk);
    end
    m_ready = 1'b0;
    nCompared++; if (count !== 5'd0) begin nMismatched++; $display("[TB] FAIL wrap_end_count: got %0d expected 0", count); end
  endtask

  task automatic test_long_pulse;
    rx_data_in = 8'h77;
    rx_done_in = 1'b1;
    repeat (50) @(negedge clk);
    rx_done_in = 1'b0;
    repeat (2) @(negedge clk);
    nCompared++; if (count !== 5'd1) begin nMismatched++; $display("[TB] FAIL long_count: got %0d expected 1", count); end
    sb.push_back(8'h77);
    m_ready = 1'b1;
    while (sb.size() > 0) begin
      expData = sb.pop_front();
      nCompared++;
      if (m_valid !== 1'b1 || m_data !== expData) begin
        nMismatched++; $display("[TB] FAIL long_drain: got v=%b %h expected v=1 %h", m_valid, m_data, expData);
      end
      @(negedge clk);
    end
    m_ready = 1'b0;
    nCompared++; if (m_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL long_empty: got %b expected 0", m_valid); end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'(8'h60 + i));
      sb.push_back(8'(8'h60 + i));
    end
    nCompared++; if (count !== 5'd5) begin nMismatched++; $display("[TB] FAIL pre_reset_count: got %0d expected 5", count); end
    #2;
    reset_n = 1'b0;
    #1;
    nCompared++; if (count !== 5'd0)   begin nMismatched++; $display("[TB] FAIL async_count: got %0d expected 0", count); end
    nCompared++; if (m_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL async_valid: got %b expected 0", m_valid); end
    nCompared++; if (m_data !== 8'h00) begin nMismatched++; $display("[TB] FAIL async_data: got %h expected 00", m_data); end
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    applyStimulus(8'h5A);
    sb.push_back(8'h5A);
    nCompared++; if (count !== 5'd1) begin nMismatched++; $display("[TB] FAIL post_reset_count: got %0d expected 1", count); end
    m_ready = 1'b1;
    while (sb.size() > 0) begin
      expData = sb.pop_front();
      nCompared++;
      if (m_valid !== 1'b1 || m_data !== expData) begin
        nMismatched++; $display("[TB] FAIL post_reset_data: got v=%b %h expected v=1 %h", m_valid, m_data, expData);
      end
      @(negedge clk);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_reset_release;
    reset_n = 1'b0;
    rx_data_in = 8'h3C;
    rx_done_in = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      nCompared++;
      if (m_valid !== (k == 3)) begin
        nMismatched++; $display("[TB] FAIL release_valid_edge%0d: got %b expected %b", k, m_valid, (k == 3));
      end
    end
    nCompared++; if (m_data !== 8'h3C) begin nMismatched++; $display("[TB] FAIL release_data: got %h expected 3c", m_data); end
    repeat (10) @(negedge clk);
    nCompared++; if (count !== 5'd1) begin nMismatched++; $display("[TB] FAIL release_count: got %0d expected 1", count); end
    rx_done_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    nCompared = 0;
    nMismatched = 0;
    test_reset();
    test_single_byte();
    test_fill_overflow();
    test_write_pop_full();
    test_wrap();
    test_long_pulse();
    test_async_reset();
    test_reset_release();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
